// File: rtl/vga_fb_arbiter.sv
// Time-slot scheduler sharing one async-SRAM framebuffer between VGA scan-out and a pixel writer.
// Optional host read port sharing the free slots: define VGA_FB_ARB_READ_PORT_EN.
module vga_fb_arbiter #(
  parameter int H_VISIBLE     = 640,
  parameter int V_VISIBLE     = 480,
  parameter int ADDR_BITS     = 20,
  parameter int DATA_BITS     = 16,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 pix_stb,
  input  logic [9:0]           column,
  input  logic [9:0]           row,
  output logic [DATA_BITS-1:0] disp_data,
  output logic                 disp_valid,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_wdata,
  output logic                 sram_data_oe,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  input  logic [DATA_BITS-1:0] sram_rdata
`ifdef VGA_FB_ARB_READ_PORT_EN
  ,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_rdata,
  output logic                 rd_rvalid
`endif
);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DISP_RD,
    SLOT_WR,
    SLOT_HOST_RD
  } slot_t;

  localparam int PTR_BITS   = $clog2(WR_FIFO_DEPTH);
  localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
  localparam logic [31:0] H_VIS_W = 32'(H_VISIBLE);
  localparam logic [31:0] V_VIS_W = 32'(V_VISIBLE);
  localparam logic [PTR_BITS:0] FIFO_FULL = (PTR_BITS + 1)'(WR_FIFO_DEPTH);

  logic                  phase_reg;
  slot_t                 slot_reg;
  slot_t                 slot_next;
  logic [ENTRY_BITS-1:0] fifo_mem [WR_FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_reg;
  logic [PTR_BITS-1:0]   rd_ptr_reg;
  logic [PTR_BITS:0]     count_reg;
  logic [PTR_BITS:0]     count_next;
  logic                  wr_ready_reg;
  logic [DATA_BITS-1:0]  cap_data_reg;
  logic                  cap_valid_reg;

  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  visible;
  logic                  free_slot;
  logic                  wr_grant;
  logic                  host_grant;
  logic [ADDR_BITS-1:0]  disp_addr;
  logic [ADDR_BITS-1:0]  head_addr;
  logic [DATA_BITS-1:0]  head_data;

  assign visible   = (32'(column) < H_VIS_W) && (32'(row) < V_VIS_W);
  assign disp_addr = ADDR_BITS'(32'(row) * H_VIS_W + 32'(column));
  assign {head_addr, head_data} = fifo_mem[rd_ptr_reg];
  assign fifo_empty = (count_reg == '0);
  // phase_reg==0 means the next edge enters phase 1 (always free); phase 0 is free only in blanking
  assign free_slot  = !phase_reg || !visible;
  assign push       = reset && wr_valid && wr_ready_reg;
  assign pop        = wr_grant;
  assign count_next = count_reg + (PTR_BITS + 1)'(push) - (PTR_BITS + 1)'(pop);
  assign pix_stb    = phase_reg;
  assign wr_ready   = wr_ready_reg;

`ifdef VGA_FB_ARB_READ_PORT_EN
  logic host_prio_reg;

  // Contested free slot goes to whichever requester lost the previous contest
  assign host_grant = reset && free_slot && rd_valid && (fifo_empty || host_prio_reg);
  assign wr_grant   = reset && free_slot && !fifo_empty && !host_grant;
  assign rd_ready   = host_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      host_prio_reg <= 1'b0;
      rd_rvalid     <= 1'b0;
      rd_rdata      <= '0;
    end else begin
      rd_rvalid <= (slot_reg == SLOT_HOST_RD);
      if (slot_reg == SLOT_HOST_RD) begin
        rd_rdata <= sram_rdata;
      end
      if (free_slot && rd_valid && !fifo_empty) begin
        host_prio_reg <= wr_grant;
      end
    end
  end
`else
  assign host_grant = 1'b0;
  assign wr_grant   = reset && free_slot && !fifo_empty;
`endif

  always_comb begin
    slot_next = SLOT_IDLE;
    if (phase_reg && visible) begin
      slot_next = SLOT_DISP_RD;
    end else if (wr_grant) begin
      slot_next = SLOT_WR;
    end else if (host_grant) begin
      slot_next = SLOT_HOST_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_reg     <= 1'b0;
      slot_reg      <= SLOT_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ready_reg  <= 1'b0;
      cap_data_reg  <= '0;
      cap_valid_reg <= 1'b0;
      disp_data     <= '0;
      disp_valid    <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_data_oe  <= 1'b0;
      sram_we_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
    end else begin
      phase_reg    <= !phase_reg;
      slot_reg     <= slot_next;
      sram_oe_n    <= !((slot_next == SLOT_DISP_RD) || (slot_next == SLOT_HOST_RD));
      sram_we_n    <= (slot_next != SLOT_WR);
      sram_data_oe <= (slot_next == SLOT_WR);
      case (slot_next)
        SLOT_DISP_RD: sram_addr <= disp_addr;
        SLOT_WR: begin
          sram_addr  <= head_addr;
          sram_wdata <= head_data;
        end
`ifdef VGA_FB_ARB_READ_PORT_EN
        SLOT_HOST_RD: sram_addr <= rd_addr;
`endif
        default: ;
      endcase

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
      end
      count_reg    <= count_next;
      wr_ready_reg <= (count_next != FIFO_FULL);

      // Capture at the end of phase 0, present for the whole following slot pair
      if (!phase_reg) begin
        cap_valid_reg <= (slot_reg == SLOT_DISP_RD);
        cap_data_reg  <= (slot_reg == SLOT_DISP_RD) ? sram_rdata : '0;
      end else begin
        disp_valid <= cap_valid_reg;
        disp_data  <= cap_data_reg;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed and random pixel/write traffic checked against a
// slot-pair reference model (write queue + reference framebuffer) with an SRAM behavioural model.
module tb_vga_fb_arbiter;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_stb;
  logic [9:0]    column;
  logic [9:0]    row;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_data_oe;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic [DW-1:0] sram_rdata;

  vga_fb_arbiter #(
    .H_VISIBLE(640), .V_VISIBLE(480), .ADDR_BITS(AW), .DATA_BITS(DW), .WR_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .pix_stb(pix_stb), .column(column), .row(row),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Async SRAM: reads follow address combinationally, writes commit at the end of a we_n cycle
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  assign sram_rdata = !sram_oe_n ? sram_mem[sram_addr] : 16'hDEAD;
  always @(posedge clk) begin
    if (!sram_we_n && sram_data_oe) sram_mem[sram_addr] <= sram_wdata;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] ref_fb [int];
  bit            m_phase;
  bit            m_ready;
  bit            pend_v;
  logic [DW-1:0] pend_d;
  logic          e_oe_n, e_we_n, e_doe, e_dv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_dd;
  bit            rand_pix;
  bit            rand_wr;
  int            passed = 0;
  int            failed = 0;
  int            total  = 0;

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a) ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] ref_read(int a);
    return ref_fb.exists(a) ? ref_fb[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_issue_write();
    wr_t w;
    if (q.size() > 0) begin
      w = q.pop_front();
      e_oe_n = 1'b1; e_we_n = 1'b0; e_doe = 1'b1;
      e_addr = w.addr; e_wdata = w.data;
      ref_fb[int'(w.addr)] = w.data;
    end else begin
      e_oe_n = 1'b1; e_we_n = 1'b1; e_doe = 1'b0;
    end
  endtask

  // What the DUT must show after the coming edge, from the inputs present before it
  task automatic model_edge();
    int a;
    if (!reset) begin
      q.delete();
      m_phase = 1'b0; m_ready = 1'b0; pend_v = 1'b0; pend_d = '0;
      e_oe_n = 1'b1; e_we_n = 1'b1; e_doe = 1'b0; e_addr = '0; e_wdata = '0;
      e_dv = 1'b0; e_dd = '0;
      return;
    end
    if (m_phase) begin
      e_dv = pend_v; e_dd = pend_d;
      if (column < 640 && row < 480) begin
        a = int'(row) * 640 + int'(column);
        e_oe_n = 1'b0; e_we_n = 1'b1; e_doe = 1'b0; e_addr = AW'(a);
        pend_v = 1'b1; pend_d = ref_read(a);
      end else begin
        pend_v = 1'b0; pend_d = '0;
        model_issue_write();
      end
    end else begin
      model_issue_write();
    end
    if (wr_valid && m_ready) q.push_back({wr_addr, wr_data});
    m_ready = (q.size() < DEPTH);
    m_phase = !m_phase;
  endtask

  task automatic pick_pixel();
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0: begin column = 10'd639; row = 10'($urandom_range(0, 3)); end
      1: begin column = 10'd640; row = 10'($urandom_range(0, 3)); end
      2: begin column = 10'($urandom_range(0, 639)); row = 10'd480; end
      3: begin column = 10'($urandom_range(641, 799)); row = 10'($urandom_range(0, 524)); end
      4: begin column = 10'($urandom_range(0, 639)); row = 10'd479; end
      default: begin column = 10'($urandom_range(0, 639)); row = 10'($urandom_range(0, 3)); end
    endcase
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("pix_stb", 32'(pix_stb), 32'(m_phase));
    chk("sram_oe_n", 32'(sram_oe_n), 32'(e_oe_n));
    chk("sram_we_n", 32'(sram_we_n), 32'(e_we_n));
    chk("sram_data_oe", 32'(sram_data_oe), 32'(e_doe));
    chk("sram_addr", 32'(sram_addr), 32'(e_addr));
    chk("sram_wdata", 32'(sram_wdata), 32'(e_wdata));
    chk("wr_ready", 32'(wr_ready), 32'(m_ready));
    chk("disp_valid", 32'(disp_valid), 32'(e_dv));
    chk("disp_data", 32'(disp_data), 32'(e_dd));
    $display("t=%0t ph=%0b col=%0d row=%0d oe_n=%0b we_n=%0b addr=%0d wdata=%h rdy=%0b dv=%0b dd=%h",
             $time, pix_stb, column, row, sram_oe_n, sram_we_n, sram_addr, sram_wdata,
             wr_ready, disp_valid, disp_data);
    if (!m_phase && rand_pix) pick_pixel();
    if (rand_wr) begin
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_addr  = AW'($urandom_range(4, 2559));
      wr_data  = DW'($urandom);
    end
  endtask

  // Move to the start of a slot pair, where the timing generator may change column/row
  task automatic to_boundary();
    if (m_phase) cycle();
  endtask

  logic [DW-1:0] seen[$];
  logic [DW-1:0] old_val;

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = init_val(i);
    reset = 1'b0; column = '0; row = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rand_pix = 1'b0; rand_wr = 1'b0;

    // Reset held 3 clk, then wr_ready must rise one clk after release
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    chk("wr_ready_after_release", 32'(wr_ready), 32'd1);

    // Display read of (5,2) -> address 1285
    to_boundary();
    sram_mem[1285] = 16'hABCD;
    ref_fb[1285]   = 16'hABCD;
    column = 10'd5; row = 10'd2;
    repeat (8) cycle();

    // Saturate the write FIFO while visible
    to_boundary();
    column = 10'd10; row = 10'd1;
    wr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_addr = AW'($urandom_range(4, 2559));
      wr_data = DW'($urandom);
      cycle();
    end
    wr_valid = 1'b0;

    // Blanking drains the queue on consecutive clocks
    to_boundary();
    column = 10'd700; row = 10'd2;
    repeat (12) cycle();

    // Read and write of address 0 in the same slot pair
    to_boundary();
    old_val = ref_read(0);
    column = 10'd0; row = 10'd0;
    wr_valid = 1'b1; wr_addr = '0; wr_data = 16'h1234;
    cycle();
    wr_valid = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (disp_valid) seen.push_back(disp_data);
    end
    chk("hazard_count", 32'(seen.size()), 32'd6);
    if (seen.size() > 0) begin
      chk("hazard_old", 32'(seen[0]), 32'(old_val));
      chk("hazard_new", 32'(seen[seen.size()-1]), 32'h1234);
    end

    // Random traffic, mid-operation reset, more random traffic
    rand_pix = 1'b1; rand_wr = 1'b1;
    repeat (1500) cycle();
    reset = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    chk("wr_ready_after_midop_reset", 32'(wr_ready), 32'd1);
    repeat (1500) cycle();
    rand_wr = 1'b0; wr_valid = 1'b0;
    repeat (20) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
